alu: RTL and testbench
======================

Name: alu

Overview:
- Registered WIDTH-bit arithmetic/logic unit with eight operations selected by a 3-bit opcode.
- Produces a result plus carry, zero, negative and overflow flags, all one clock after the operands are presented.
- Sits in the datapath as the execute stage; inputs are sampled every cycle, with no handshake.

Parameters:
- WIDTH, 4, operand and result width in bits (must be ≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- A  input  WIDTH  operand A, unsigned or two's complement depending on the flag being read.
- B  input  WIDTH  operand B.
- ALU_Sel  input  3  operation select.
- in_valid  input  1  qualifies A/B/ALU_Sel this cycle.
- ALU_Out  output  WIDTH  registered result.
- carry  output  1  carry-out or no-borrow; shifted-out bit for shifts.
- zero  output  1  ALU_Out == 0.
- negative  output  1  ALU_Out[WIDTH-1].
- overflow  output  1  signed overflow (add/sub only).
- out_valid  output  1  registered in_valid; marks the cycle ALU_Out/flags reflect a new operation.

Behaviour:
- Reset: rst high asynchronously clears ALU_Out, carry, negative, overflow and out_valid to 0, and sets zero to 1 (zero is consistent with ALU_Out=0). Registers stay in that state while rst is high. On release, the first rising edge samples inputs normally. Reset asserted mid-stream discards any in-flight result.
- Latency: exactly 1 cycle. At each rising clk edge with in_valid=1, the result of the currently presented A, B and ALU_Sel is registered into ALU_Out/flags and out_valid<=1.
- When in_valid=0: ALU_Out and flags hold their previous values and out_valid<=0.
- Opcodes (all results truncated to WIDTH bits):
  - 000 ADD: A+B; carry = bit WIDTH of the (WIDTH+1)-bit sum; overflow = A and B have the same sign and the result sign differs.
  - 001 SUB: A-B; carry = 1 when A ≥ B unsigned (no borrow); overflow = A and B have different signs and the result sign differs from A.
  - 010 AND: A & B.
  - 011 OR: A | B.
  - 100 NOT: ~A; B is ignored.
  - 101 XOR: A ^ B.
  - 110 SHL: A << 1, zero fill; carry = A[WIDTH-1].
  - 111 SHR: logical A >> 1, zero fill; carry = A[0].
- Carry is 0 for opcodes 010–101. Overflow is 0 for every opcode other than 000 and 001.
- zero and negative are derived from the registered result for every opcode.
- Wrap-around: ADD 1111+0001 gives 0000 with carry=1 and zero=1. SUB 0000-0001 gives 1111 with carry=0.
- No X propagation from unused opcode paths. The select decode is fully specified (a default branch is not reachable but must be coded to 0).
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst asynchronously between edges. Outputs clear immediately: ALU_Out=0000, zero=1, other flags 0, out_valid=0. Release rst; the first edge with in_valid=1 produces a valid result.
- Reference ops, A=0101, B=0011, in_valid=1, one op per cycle in order 000, 001, 010, 011, 100. Required ALU_Out values one cycle later: 1000, 0010, 0001, 0111, 1010. ADD must show overflow=1, negative=1, carry=0; SUB must show carry=1.
- Remaining ops, A=0101, B=0011:
  - 101 → 0110.
  - 110 → 1010, carry=0.
  - 111 → 0010, carry=1.
- Boundaries:
  - ADD 1111+0001 → 0000, carry=1, zero=1, overflow=0.
  - SUB 0000-0001 → 1111, carry=0, negative=1.
  - SUB 1000-0001 → 0111, overflow=1.
- Hold: after a valid result, drive in_valid=0 and change A/B/ALU_Sel randomly for 5 cycles. ALU_Out and flags must stay constant and out_valid must be 0.
- Back-to-back: change ALU_Sel every cycle with in_valid=1. Each output must match the previous cycle's inputs (1-cycle latency, no bubbles).

Source files
------------

// File: rtl/alu.sv
// Registered execute-stage ALU: eight ops, result plus carry/zero/negative/overflow flags.
// All outputs update one clock after a qualified operation; they hold while in_valid is low.
module alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH-1:0] res_d, res_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  logic             neg_d, neg_q;
  logic             ovf_d, ovf_q;
  logic             valid_d, valid_q;

  logic [WIDTH:0]   sum, diff;
  logic             sign_a, sign_b;

  assign sum    = {1'b0, A} + {1'b0, B};
  assign diff   = {1'b0, A} - {1'b0, B};
  assign sign_a = A[WIDTH-1];
  assign sign_b = B[WIDTH-1];

  always_comb begin
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = in_valid;
    if (in_valid) begin
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      case (ALU_Sel)
        3'b000: begin
          res_d   = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
          ovf_d   = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
        end
        3'b001: begin
          res_d   = diff[WIDTH-1:0];
          // Borrow appears in the extra bit; carry means "no borrow".
          carry_d = ~diff[WIDTH];
          ovf_d   = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
        end
        3'b010: res_d = A & B;
        3'b011: res_d = A | B;
        3'b100: res_d = ~A;
        3'b101: res_d = A ^ B;
        3'b110: begin
          res_d   = {A[WIDTH-2:0], 1'b0};
          carry_d = A[WIDTH-1];
        end
        3'b111: begin
          res_d   = {1'b0, A[WIDTH-1:1]};
          carry_d = A[0];
        end
        default: begin
          res_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
      endcase
    end
    zero_d = (res_d == '0);
    neg_d  = res_d[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign ALU_Out   = res_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu (WIDTH=4); expected values packed as
// {ALU_Out, carry, zero, negative, overflow, out_valid}.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [3:0] a, b;
  logic [2:0] sel;
  logic       in_valid;
  logic [3:0] alu_out;
  logic       carry, zero, negative, overflow, out_valid;

  int n_cmp;
  int n_bad;

  alu #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .ALU_Sel  (sel),
    .in_valid (in_valid),
    .ALU_Out  (alu_out),
    .carry    (carry),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [8:0] exp;
  } vec_t;

  vec_t vt[16];

  function automatic logic [8:0] observed();
    return {alu_out, carry, zero, negative, overflow, out_valid};
  endfunction

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = observed();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got out=%b c=%b z=%b n=%b v=%b ov=%b, want out=%b c=%b z=%b n=%b v=%b ov=%b",
               name, got[8:5], got[4], got[3], got[2], got[1], got[0],
               exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive on the falling edge, check 1 time unit after the next rising edge.
  task automatic apply(input logic [2:0] s, input logic [3:0] x, input logic [3:0] y,
                       input logic v);
    @(negedge clk);
    sel      = s;
    a        = x;
    b        = y;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Integer-arithmetic reference used for the randomised back-to-back stream.
  function automatic logic [8:0] model(input logic [2:0] s, input logic [3:0] x,
                                       input logic [3:0] y);
    int ua, ub, sa, sb, r, sr;
    logic [3:0] o;
    logic c, v;
    ua = int'(x);
    ub = int'(y);
    sa = x[3] ? ua - 16 : ua;
    sb = y[3] ? ub - 16 : ub;
    c = 1'b0;
    v = 1'b0;
    o = 4'b0000;
    case (s)
      3'd0: begin r = ua + ub; o = r[3:0]; c = (r > 15); sr = sa + sb; v = (sr > 7) || (sr < -8); end
      3'd1: begin r = ua - ub; o = r[3:0]; c = (ua >= ub); sr = sa - sb; v = (sr > 7) || (sr < -8); end
      3'd2: o = x & y;
      3'd3: o = x | y;
      3'd4: o = ~x;
      3'd5: o = x ^ y;
      3'd6: begin r = (ua * 2) % 16; o = r[3:0]; c = (ua >= 8); end
      default: begin r = ua / 2; o = r[3:0]; c = (ua % 2) == 1; end
    endcase
    return {o, c, (o == 4'b0000), o[3], v, 1'b1};
  endfunction

  initial begin
    logic [8:0] held;
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    a        = '0;
    b        = '0;
    sel      = '0;
    in_valid = 1'b0;

    vt[0]  = '{"add_ref",  3'b000, 4'b0101, 4'b0011, {4'b1000, 5'b00111}};
    vt[1]  = '{"sub_ref",  3'b001, 4'b0101, 4'b0011, {4'b0010, 5'b10001}};
    vt[2]  = '{"and_ref",  3'b010, 4'b0101, 4'b0011, {4'b0001, 5'b00001}};
    vt[3]  = '{"or_ref",   3'b011, 4'b0101, 4'b0011, {4'b0111, 5'b00001}};
    vt[4]  = '{"not_ref",  3'b100, 4'b0101, 4'b0011, {4'b1010, 5'b00101}};
    vt[5]  = '{"xor_ref",  3'b101, 4'b0101, 4'b0011, {4'b0110, 5'b00001}};
    vt[6]  = '{"shl_ref",  3'b110, 4'b0101, 4'b0011, {4'b1010, 5'b00101}};
    vt[7]  = '{"shr_ref",  3'b111, 4'b0101, 4'b0011, {4'b0010, 5'b10001}};
    vt[8]  = '{"add_wrap", 3'b000, 4'b1111, 4'b0001, {4'b0000, 5'b11001}};
    vt[9]  = '{"sub_wrap", 3'b001, 4'b0000, 4'b0001, {4'b1111, 5'b00101}};
    vt[10] = '{"sub_ovf",  3'b001, 4'b1000, 4'b0001, {4'b0111, 5'b10011}};
    vt[11] = '{"add_ovf",  3'b000, 4'b0111, 4'b0001, {4'b1000, 5'b00111}};
    vt[12] = '{"sub_eq",   3'b001, 4'b0011, 4'b0011, {4'b0000, 5'b11001}};
    vt[13] = '{"shl_out",  3'b110, 4'b1000, 4'b0110, {4'b0000, 5'b11001}};
    vt[14] = '{"shr_out",  3'b111, 4'b0001, 4'b1001, {4'b0000, 5'b11001}};
    vt[15] = '{"not_zero", 3'b100, 4'b1111, 4'b0000, {4'b0000, 5'b01001}};

    #2;
    check("reset_state", {4'b0000, 5'b01000});
    @(negedge clk);
    rst = 1'b0;

    // Table applied back to back: one new op per cycle, in_valid held high.
    for (int i = 0; i < 16; i++) begin
      apply(vt[i].sel, vt[i].a, vt[i].b, 1'b1);
      check(vt[i].name, vt[i].exp);
    end

    held = {4'b0000, 5'b01000};
    for (int i = 0; i < 5; i++) begin
      apply(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'b0);
      check("hold", held);
    end

    for (int i = 0; i < 24; i++) begin
      logic [2:0] s;
      logic [3:0] x, y;
      s = 3'(i % 8);
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      apply(s, x, y, 1'b1);
      check("b2b_rand", model(s, x, y));
    end

    // Mid-stream async reset between edges discards the in-flight result.
    @(negedge clk);
    sel      = 3'b000;
    a        = 4'b0101;
    b        = 4'b0011;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {4'b0000, 5'b01000});
    @(posedge clk);
    #1;
    check("reset_held", {4'b0000, 5'b01000});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_after_reset", {4'b1000, 5'b00111});

    apply(3'b001, 4'b0101, 4'b0011, 1'b1);
    check("sub_after_reset", {4'b0010, 5'b10001});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
